// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: type-field layout, flit type encodings and arbiter FSM states.
// Used by the packet generators, the injection arbiter and the router input stage.
package noc_pkg;

  localparam int FLIT_W   = 64;
  localparam int TYPE_MSB = FLIT_W - 1;
  localparam int TYPE_LSB = FLIT_W - 2;

  typedef enum logic [1:0] {
    FLIT_TYPE_ILLEGAL = 2'b00,
    FLIT_TYPE_BODY    = 2'b01,
    FLIT_TYPE_TAIL    = 2'b10,
    FLIT_TYPE_HEAD    = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Takes the two type bits rather than a whole flit so callers with a non-default width can reuse it.
  function automatic flit_type_e flit_type(input logic [1:0] type_bits);
    return flit_type_e'(type_bits);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping N-1 -> 0.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  int j;

  // NOTE: every always_comb output gets a default before any branch so no latch can be inferred.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j       = 0;
    // Walk offsets from farthest to nearest so the nearest requester is the last (winning) assignment.
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/flit_inject_arbiter.sv
// Wormhole injection arbiter: round-robin grant on a head flit, held until the owner's tail is accepted.
// Flits and handshakes pass through combinationally while locked; counts packets and flags protocol errors.
module flit_inject_arbiter #(
  parameter int N_SRC  = 4,
  parameter int FLIT_W = noc_pkg::FLIT_W,
  parameter int CNT_W  = 32,
  parameter int IDX_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_SRC*FLIT_W-1:0] src_flit,
  input  logic [N_SRC-1:0]        src_wr_req,
  output logic [N_SRC-1:0]        src_wr_ack,
  output logic [FLIT_W-1:0]       out_flit,
  output logic                    out_wr_req,
  input  logic                    out_wr_ack,
  output logic                    grant_vld,
  output logic [IDX_W-1:0]        grant_idx,
  output logic [CNT_W-1:0]        pkt_count,
  output logic                    protocol_err
);

  import noc_pkg::*;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             first_beat_q, first_beat_d;

  logic [N_SRC-1:0] eligible;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_vld;

  logic [FLIT_W-1:0] sel_flit;
  logic              sel_req;
  flit_type_e        sel_type;
  logic              xfer;
  logic              bad_beat;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_SRC; i++) begin
      eligible[i] = src_wr_req[i] &&
                    (flit_type(src_flit[i*FLIT_W + FLIT_W - 2 +: 2]) == FLIT_TYPE_HEAD);
    end
  end

  rr_arbiter #(
    .N     (N_SRC),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req     (eligible),
    .ptr     (rr_ptr_q),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  assign sel_flit = src_flit[grant_idx_q*FLIT_W +: FLIT_W];
  assign sel_req  = src_wr_req[grant_idx_q];
  assign sel_type = flit_type(sel_flit[FLIT_W-1 -: 2]);
  assign xfer     = (state_q == ST_LOCKED) && sel_req && out_wr_ack;

  // The first beat must still be the head that won arbitration; later heads mean a missing tail.
  assign bad_beat = (sel_type == FLIT_TYPE_ILLEGAL) ||
                    ( first_beat_q && (sel_type != FLIT_TYPE_HEAD)) ||
                    (!first_beat_q && (sel_type == FLIT_TYPE_HEAD));

  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    first_beat_d = first_beat_q;
    out_flit     = '0;
    out_wr_req   = 1'b0;
    src_wr_ack   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          grant_idx_d  = arb_idx;
          first_beat_d = 1'b1;
          state_d      = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        out_flit                = sel_flit;
        out_wr_req              = sel_req;
        src_wr_ack[grant_idx_q] = out_wr_ack & sel_req;
        if (xfer) begin
          first_beat_d = 1'b0;
          if (bad_beat) err_d = 1'b1;
          if (sel_type == FLIT_TYPE_TAIL) begin
            cnt_d    = cnt_q + CNT_W'(1);
            rr_ptr_d = (grant_idx_q == IDX_W'(N_SRC - 1)) ? '0 : grant_idx_q + IDX_W'(1);
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_idx_q  <= '0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      first_beat_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      first_beat_q <= first_beat_d;
    end
  end

  assign grant_vld    = (state_q == ST_LOCKED);
  assign grant_idx    = grant_idx_q;
  assign pkt_count    = cnt_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_flit_inject_arbiter.sv
// Directed bench for flit_inject_arbiter: round-robin order, wormhole locking, backpressure,
// protocol errors and mid-packet reset, all against hand-computed expectations.
module tb_flit_inject_arbiter;

  localparam int N = 4;
  localparam int W = 64;
  localparam logic [1:0] H = 2'b11;
  localparam logic [1:0] B = 2'b01;
  localparam logic [1:0] T = 2'b10;
  localparam logic [1:0] X = 2'b00;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] src_flit;
  logic [N-1:0]   src_wr_req;
  logic [N-1:0]   src_wr_ack;
  logic [W-1:0]   out_flit;
  logic           out_wr_req;
  logic           out_wr_ack;
  logic           grant_vld;
  logic [1:0]     grant_idx;
  logic [31:0]    pkt_count;
  logic           protocol_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  flit_inject_arbiter #(.N_SRC(N), .FLIT_W(W), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .src_flit     (src_flit),
    .src_wr_req   (src_wr_req),
    .src_wr_ack   (src_wr_ack),
    .out_flit     (out_flit),
    .out_wr_req   (out_wr_req),
    .out_wr_ack   (out_wr_ack),
    .grant_vld    (grant_vld),
    .grant_idx    (grant_idx),
    .pkt_count    (pkt_count),
    .protocol_err (protocol_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] t, input int p);
    return {t, 62'(p)};
  endfunction

  task automatic drive(input int i, input logic [1:0] t, input int p, input logic r);
    src_flit[i*W +: W] = mk(t, p);
    src_wr_req[i]      = r;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    src_flit   = '0;
    src_wr_req = '0;
    out_wr_ack = 1'b0;
    reset      = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    #1;
    check("rst_grant_vld", grant_vld, 0);
    check("rst_out_wr_req", out_wr_req, 0);
    check("rst_src_wr_ack", src_wr_ack, 0);
    check("rst_out_flit", out_flit, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_err", protocol_err, 0);

    // src0: head, body, body, tail with the router always ready
    drive(0, H, 'h100, 1);
    out_wr_ack = 1'b1;
    #1;
    check("t1_idle_no_req", out_wr_req, 0);
    check("t1_idle_no_ack", src_wr_ack, 0);
    tick;
    check("t1_grant_vld", grant_vld, 1);
    check("t1_grant_idx", grant_idx, 0);
    check("t1_head_fwd", out_flit, mk(H, 'h100));
    check("t1_head_ack", src_wr_ack, 4'b0001);
    tick;
    drive(0, B, 'h101, 1);
    #1;
    check("t1_body_fwd", out_flit, mk(B, 'h101));
    tick;
    drive(0, B, 'h102, 1);
    tick;
    drive(0, T, 'h103, 1);
    #1;
    check("t1_tail_ack", src_wr_ack, 4'b0001);
    check("t1_cnt_before_tail", pkt_count, 0);
    tick;

    // rr_ptr=1: src0 and src1 both present heads, src1 must win
    drive(0, H, 'h200, 1);
    drive(1, H, 'h300, 1);
    #1;
    check("t1_bubble", grant_vld, 0);
    check("t1_pkt_count", pkt_count, 1);
    tick;
    check("t1b_grant_idx", grant_idx, 1);
    check("t1b_ack_only_src1", src_wr_ack, 4'b0010);
    tick;
    drive(1, T, 'h301, 1);
    #1;
    check("t1b_tail_ack", src_wr_ack, 4'b0010);
    tick;

    // rr_ptr=2: src1 and src3 heads together, src3 wins, then src1
    drive(0, B, 0, 0);
    drive(1, H, 'h400, 1);
    drive(3, H, 'h500, 1);
    #1;
    check("t2_pkt_count_a", pkt_count, 2);
    tick;
    check("t2_grant_src3", grant_idx, 3);
    check("t2_ack_src3", src_wr_ack, 4'b1000);
    check("t2_head_src3", out_flit, mk(H, 'h500));
    tick;
    drive(3, T, 'h501, 1);
    tick;
    drive(3, B, 0, 0);
    #1;
    check("t2_bubble", grant_vld, 0);
    check("t2_pkt_count_b", pkt_count, 3);
    tick;
    check("t2_grant_src1", grant_idx, 1);
    check("t2_head_src1", out_flit, mk(H, 'h400));
    tick;
    drive(1, B, 'h401, 1);
    tick;
    drive(1, T, 'h402, 1);
    tick;

    // src2 with router backpressure for three cycles mid-body
    drive(1, B, 0, 0);
    drive(2, H, 'h600, 1);
    tick;
    check("t3_grant_src2", grant_idx, 2);
    tick;
    drive(2, B, 'h601, 1);
    out_wr_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_hold_flit", out_flit, mk(B, 'h601));
      check("t3_hold_req", out_wr_req, 1);
      check("t3_hold_no_ack", src_wr_ack, 0);
      check("t3_hold_grant", grant_idx, 2);
      tick;
    end
    out_wr_ack = 1'b1;
    #1;
    check("t3_resume_ack", src_wr_ack, 4'b0100);
    check("t3_still_body", out_flit, mk(B, 'h601));
    tick;
    drive(2, T, 'h602, 1);
    tick;
    drive(2, B, 0, 0);
    drive(3, H, 'h700, 1);
    #1;
    check("t3_pkt_count", pkt_count, 5);

    // src3 drops its request mid-packet while src0 waits with a head
    tick;
    check("t4_grant_src3", grant_idx, 3);
    tick;
    drive(3, B, 'h701, 0);
    drive(0, H, 'h800, 1);
    for (int k = 0; k < 2; k++) begin
      #1;
      check("t4_gap_no_req", out_wr_req, 0);
      check("t4_gap_no_ack", src_wr_ack, 0);
      check("t4_gap_grant", grant_idx, 3);
      check("t4_gap_vld", grant_vld, 1);
      tick;
    end
    drive(3, B, 'h701, 1);
    #1;
    check("t4_body_ack", src_wr_ack, 4'b1000);
    tick;
    drive(3, T, 'h702, 1);
    #1;
    check("t4_tail_ack", src_wr_ack, 4'b1000);
    tick;
    drive(3, B, 0, 0);
    #1;
    check("t4_bubble", grant_vld, 0);
    check("t4_pkt_count", pkt_count, 6);

    // src0: head, body, head -> error on the second head, packet stays locked
    tick;
    check("t5_grant_src0", grant_idx, 0);
    check("t5_err_clear", protocol_err, 0);
    tick;
    drive(0, B, 'h801, 1);
    tick;
    drive(0, H, 'h802, 1);
    #1;
    check("t5_err_before", protocol_err, 0);
    tick;
    check("t5_err_set", protocol_err, 1);
    check("t5_still_locked", grant_vld, 1);
    check("t5_still_src0", grant_idx, 0);

    // reset while src0 is mid-body
    drive(0, B, 'h803, 1);
    reset = 1'b1;
    tick;
    check("t6_grant_vld", grant_vld, 0);
    check("t6_out_wr_req", out_wr_req, 0);
    check("t6_pkt_count", pkt_count, 0);
    check("t6_err", protocol_err, 0);
    check("t6_src_wr_ack", src_wr_ack, 0);
    check("t6_out_flit", out_flit, 0);
    reset = 1'b0;
    drive(0, B, 0, 0);

    // src1 sends an illegal-type flit mid-packet
    drive(1, H, 'h900, 1);
    tick;
    check("t7_grant_src1", grant_idx, 1);
    tick;
    drive(1, X, 'h901, 1);
    #1;
    check("t7_err_before", protocol_err, 0);
    tick;
    check("t7_err_set", protocol_err, 1);
    check("t7_locked", grant_vld, 1);
    drive(1, T, 'h902, 1);
    tick;
    check("t7_done", grant_vld, 0);
    check("t7_pkt_count", pkt_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
